rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_pkg.sv | 31 +++
 rtl/rob_ptr_ctrl.sv | 57 +++++
 rtl/rob_queue.sv | 176 +++++++++++++++++
 tb/tb_rob_queue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and default constants for the reorder buffer.
// Optional same-cycle CDB forwarding on the operand lookup is enabled by ROB_CDB_BYPASS_EN.
package rob_pkg;

  localparam int unsigned RobDepth    = 16;
  localparam int unsigned RobDataW    = 32;
  localparam int unsigned RobCdbPorts = 2;
  localparam int unsigned RobRegW     = 5;

  typedef enum logic [2:0] {
    OpAlu    = 3'd0,
    OpLoad   = 3'd1,
    OpStore  = 3'd2,
    OpBranch = 3'd3,
    OpHalt   = 3'd4
  } rob_op_e;

  // Width-independent per-entry state; parameter-width payload lives in rob_queue.
  typedef struct packed {
    rob_op_e op;
    logic    pred;
    logic    taken;
    logic    occupied;
    logic    ready;
  } rob_meta_t;

  function automatic logic is_mispredict(rob_meta_t m);
    return (m.op == OpBranch) && (m.taken != m.pred);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the circular reorder buffer.
module rob_ptr_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_fire_i,
  input  logic             commit_fire_i,
  input  logic             clear_i,
  output logic [IDX_W-1:0] head_o,
  output logic [IDX_W-1:0] tail_o,
  output logic [IDX_W:0]   count_o,
  output logic             full_o
);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly IDX_W bits, so DEPTH-1 -> 0 wraps for free.
      if (alloc_fire_i)  tail_d = tail_q + IDX_W'(1);
      if (commit_fire_i) head_d = head_q + IDX_W'(1);
      unique case ({alloc_fire_i, commit_fire_i})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (IDX_W+1)'(DEPTH));

endmodule

// File: rtl/rob_queue.sv
// In-order-retire reorder buffer with multi-port CDB completion, branch flush and halt.
// Build option: ROB_CDB_BYPASS_EN forwards same-cycle CDB writes onto rd_ready/rd_data.
module rob_queue
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = RobDepth,
  parameter int unsigned DATA_W    = RobDataW,
  parameter int unsigned CDB_PORTS = RobCdbPorts,
  parameter int unsigned REG_W     = RobRegW,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [2:0]                    alloc_op,
  input  logic [REG_W-1:0]              alloc_dest,
  input  logic [DATA_W-1:0]             alloc_pc,
  input  logic                          alloc_pred,
  output logic [IDX_W-1:0]              alloc_tag,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_addr,
  input  logic [CDB_PORTS-1:0]          cdb_taken,
  input  logic [IDX_W-1:0]              rd_tag,
  output logic                          rd_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          commit_valid,
  input  logic                          commit_ready,
  output logic [2:0]                    commit_op,
  output logic [REG_W-1:0]              commit_dest,
  output logic [DATA_W-1:0]             commit_data,
  output logic [DATA_W-1:0]             commit_addr,
  output logic [IDX_W-1:0]              commit_tag,
  output logic                          flush,
  output logic [DATA_W-1:0]             flush_pc,
  output logic                          halt,
  output logic [IDX_W:0]                count
);

  rob_meta_t         meta_q [DEPTH];
  rob_meta_t         meta_d [DEPTH];
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] pc_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] addr_d [DEPTH];

  logic              halt_q, halt_d, flush_q, flush_d;
  logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

  logic [IDX_W-1:0]  head, tail;
  logic              full;
  logic              alloc_fire, commit_fire, mispredict, halt_retire;
  rob_meta_t         head_meta;

  rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ptr (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_fire_i  (alloc_fire),
    .commit_fire_i (commit_fire),
    .clear_i       (mispredict),
    .head_o        (head),
    .tail_o        (tail),
    .count_o       (count),
    .full_o        (full)
  );

  assign head_meta    = meta_q[head];
  assign alloc_ready  = !full && !halt_q;
  assign alloc_tag    = tail;
  assign commit_valid = head_meta.occupied && head_meta.ready && !halt_q;
  assign commit_fire  = commit_valid && commit_ready;
  assign mispredict   = commit_fire && is_mispredict(head_meta);
  assign halt_retire  = commit_fire && (head_meta.op == OpHalt);
  // A flushing or halting retire squashes whatever tries to allocate on the same edge.
  assign alloc_fire   = alloc_valid && alloc_ready && !mispredict && !halt_retire;

  assign commit_op   = head_meta.op;
  assign commit_dest = dest_q[head];
  assign commit_data = data_q[head];
  assign commit_addr = addr_q[head];
  assign commit_tag  = head;

  always_comb begin
    meta_d = meta_q;
    dest_d = dest_q;
    pc_d   = pc_q;
    data_d = data_q;
    addr_d = addr_q;
    // Ascending port order: the highest-indexed port writing a tag lands last.
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && meta_q[cdb_tag[p*IDX_W +: IDX_W]].occupied) begin
        data_d[cdb_tag[p*IDX_W +: IDX_W]]       = cdb_data[p*DATA_W +: DATA_W];
        addr_d[cdb_tag[p*IDX_W +: IDX_W]]       = cdb_addr[p*DATA_W +: DATA_W];
        meta_d[cdb_tag[p*IDX_W +: IDX_W]].taken = cdb_taken[p];
        meta_d[cdb_tag[p*IDX_W +: IDX_W]].ready = 1'b1;
      end
    end
    if (commit_fire) begin
      meta_d[head].occupied = 1'b0;
      meta_d[head].ready    = 1'b0;
    end
    if (alloc_fire) begin
      meta_d[tail] = '{op:       rob_op_e'(alloc_op),
                       pred:     alloc_pred,
                       taken:    1'b0,
                       occupied: 1'b1,
                       ready:    (rob_op_e'(alloc_op) == OpHalt)};
      dest_d[tail] = alloc_dest;
      pc_d[tail]   = alloc_pc;
    end
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_d[i].occupied = 1'b0;
        meta_d[i].ready    = 1'b0;
      end
    end
  end

  always_comb begin
    halt_d     = halt_q | halt_retire;
    flush_d    = mispredict;
    flush_pc_d = flush_pc_q;
    if (mispredict) begin
      flush_pc_d = head_meta.taken ? addr_q[head] : pc_q[head] + DATA_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '{default: '0};
      halt_q     <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      meta_q     <= meta_d;
      halt_q     <= halt_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Payload is only meaningful while occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    pc_q   <= pc_d;
    data_q <= data_d;
    addr_q <= addr_d;
  end

  always_comb begin
    rd_ready = meta_q[rd_tag].occupied && meta_q[rd_tag].ready;
    rd_data  = data_q[rd_tag];
`ifdef ROB_CDB_BYPASS_EN
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*IDX_W +: IDX_W] == rd_tag) && meta_q[rd_tag].occupied) begin
        rd_ready = 1'b1;
        rd_data  = cdb_data[p*DATA_W +: DATA_W];
      end
    end
`endif
  end

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_rob_queue.sv
// Scoreboard-driven bench for rob_queue: fill, out-of-order completion, wrap, flush, CDB, halt.
module tb_rob_queue;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CDB_PORTS = 2;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IDX_W     = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        alloc_valid, alloc_ready, alloc_pred;
  logic [2:0]                  alloc_op;
  logic [REG_W-1:0]            alloc_dest;
  logic [DATA_W-1:0]           alloc_pc;
  logic [IDX_W-1:0]            alloc_tag;
  logic [CDB_PORTS-1:0]        cdb_valid, cdb_taken;
  logic [CDB_PORTS*IDX_W-1:0]  cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0] cdb_data, cdb_addr;
  logic [IDX_W-1:0]            rd_tag;
  logic                        rd_ready;
  logic [DATA_W-1:0]           rd_data;
  logic                        commit_valid, commit_ready;
  logic [2:0]                  commit_op;
  logic [REG_W-1:0]            commit_dest;
  logic [DATA_W-1:0]           commit_data, commit_addr;
  logic [IDX_W-1:0]            commit_tag;
  logic                        flush, halt;
  logic [DATA_W-1:0]           flush_pc;
  logic [IDX_W:0]              count;

  rob_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_op     (alloc_op),
    .alloc_dest   (alloc_dest),
    .alloc_pc     (alloc_pc),
    .alloc_pred   (alloc_pred),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_addr     (cdb_addr),
    .cdb_taken    (cdb_taken),
    .rd_tag       (rd_tag),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_op    (commit_op),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .commit_addr  (commit_addr),
    .commit_tag   (commit_tag),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .halt         (halt),
    .count        (count)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_ALU = 3'd0, OP_BRANCH = 3'd3, OP_HALT = 3'd4;

  typedef struct {
    logic [IDX_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [2:0]        op;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   max_count = 0;

  always @(negedge clk) if (int'(count) > max_count) max_count = int'(count);

  initial begin
    #300000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    alloc_valid = 0; alloc_op = OP_ALU; alloc_dest = '0; alloc_pc = '0; alloc_pred = 0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; cdb_addr = '0; cdb_taken = '0;
    rd_tag = '0; commit_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    rst_n = 1;
    sb.delete();
    max_count = 0;
    next_cycle();
  endtask

  task automatic do_alloc(input logic [2:0] op, input logic [DATA_W-1:0] pc, input logic pred);
    alloc_valid = 1; alloc_op = op; alloc_dest = pc[REG_W-1:0]; alloc_pc = pc; alloc_pred = pred;
    next_cycle();
    alloc_valid = 0;
  endtask

  task automatic do_cdb(input int port, input int tag, input logic [DATA_W-1:0] data,
                        input logic [DATA_W-1:0] addr, input logic taken);
    cdb_valid = '0;
    cdb_valid[port] = 1'b1;
    cdb_tag[port*IDX_W +: IDX_W]   = IDX_W'(tag);
    cdb_data[port*DATA_W +: DATA_W] = data;
    cdb_addr[port*DATA_W +: DATA_W] = addr;
    cdb_taken[port] = taken;
    next_cycle();
    cdb_valid = '0;
  endtask

  // Allocate one ALU op, complete it on CDB port 0 next cycle, and record the expected retire.
  task automatic alloc_complete(input int serial);
    exp_t e;
    e.tag = alloc_tag; e.data = 32'hC000_0000 + DATA_W'(serial); e.op = OP_ALU;
    do_alloc(OP_ALU, DATA_W'(serial * 4), 1'b0);
    do_cdb(0, int'(e.tag), e.data, '0, 1'b0);
    sb.push_back(e);
  endtask

  task automatic drain_scoreboard(input string name, input int max_n);
    exp_t e;
    int   waited;
    int   done = 0;
    while (sb.size() > 0 && done < max_n) begin
      waited = 0;
      while (commit_valid !== 1'b1 && waited < 50) begin
        next_cycle();
        waited++;
      end
      if (commit_valid !== 1'b1) begin
        n_checks++;
        $display("FAIL %s_timeout got commit_valid=%b exp=1", name, commit_valid);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      n_checks++;
      if (commit_tag !== e.tag || commit_data !== e.data || commit_op !== e.op)
        $display("FAIL %s_commit got tag=%0d data=%h op=%0d exp tag=%0d data=%h op=%0d",
                 name, commit_tag, commit_data, commit_op, e.tag, e.data, e.op);
      else n_pass++;
      commit_ready = 1;
      next_cycle();
      commit_ready = 0;
      done++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_checks++; if (commit_valid !== 1'b0 || halt !== 1'b0 || flush !== 1'b0)
      $display("FAIL reset_held got cv=%b halt=%b flush=%b exp 0 0 0", commit_valid, halt, flush);
    else n_pass++;
    #9;
    rst_n = 1;
    next_cycle();
    n_checks++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready);
    else n_pass++;
    n_checks++; if (alloc_tag !== '0) $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag);
    else n_pass++;
    n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b0 || halt !== 1'b0)
      $display("FAIL reset_outputs got cv=%b flush=%b halt=%b exp 0 0 0", commit_valid, flush, halt);
    else n_pass++;
  endtask

  task automatic test_fill();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (alloc_tag !== IDX_W'(i) || alloc_ready !== 1'b1)
        $display("FAIL fill_tag got tag=%0d rdy=%b exp tag=%0d rdy=1", alloc_tag, alloc_ready, i);
      else n_pass++;
      do_alloc(OP_ALU, DATA_W'(32'h40 + i), 1'b0);
    end
    n_checks++; if (alloc_ready !== 1'b0 || count !== 5'd16)
      $display("FAIL fill_full got rdy=%b count=%0d exp rdy=0 count=16", alloc_ready, count);
    else n_pass++;
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL fill_no_commit got=%b exp=0", commit_valid);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      e.tag = IDX_W'(i); e.data = 32'h1000 + DATA_W'(i); e.op = OP_ALU;
      do_cdb(i % 2, i, e.data, '0, 1'b0);
      sb.push_back(e);
    end
    // Full queue retiring this cycle must still refuse the new allocation.
    alloc_valid = 1; alloc_op = OP_ALU;
    #1;
    n_checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1)
      $display("FAIL full_commit_refuse got rdy=%b cv=%b exp rdy=0 cv=1", alloc_ready, commit_valid);
    else n_pass++;
    drain_scoreboard("full_commit", 1);
    alloc_valid = 0;
    n_checks++; if (count !== 5'd15 || alloc_tag !== 4'd0)
      $display("FAIL full_commit_count got count=%0d tag=%0d exp 15 0", count, alloc_tag);
    else n_pass++;
    drain_scoreboard("fill", 100);
    n_checks++; if (count !== '0) $display("FAIL fill_drained got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_ooo();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_alloc(OP_ALU, DATA_W'(32'h80 + 4 * i), 1'b0);
      e.tag = IDX_W'(i); e.data = 32'hD0 + DATA_W'(i); e.op = OP_ALU;
      sb.push_back(e);
    end
    do_cdb(0, 2, 32'hD2, '0, 1'b0);
    n_checks++; if (commit_valid !== 1'b0)
      $display("FAIL ooo_head_wait got=%b exp=0", commit_valid);
    else n_pass++;
    do_cdb(1, 0, 32'hD0, '0, 1'b0);
    do_cdb(0, 1, 32'hD1, '0, 1'b0);
    drain_scoreboard("ooo", 100);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (alloc_tag !== IDX_W'(i))
        $display("FAIL wrap_tag got=%0d exp=%0d", alloc_tag, i);
      else n_pass++;
      alloc_complete(i);
    end
    n_checks++; if (count !== 5'd16 || alloc_ready !== 1'b0)
      $display("FAIL wrap_full got count=%0d rdy=%b exp 16 0", count, alloc_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drain_scoreboard("wrap_step", 1);
      n_checks++; if (alloc_tag !== IDX_W'(i) || alloc_ready !== 1'b1)
        $display("FAIL wrap_tag2 got tag=%0d rdy=%b exp tag=%0d rdy=1", alloc_tag, alloc_ready, i);
      else n_pass++;
      alloc_complete(16 + i);
    end
    drain_scoreboard("wrap", 100);
    n_checks++; if (max_count > 16) $display("FAIL wrap_max_count got=%0d exp<=16", max_count);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    logic [IDX_W-1:0] t;
    apply_reset();
    do_alloc(OP_BRANCH, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) do_alloc(OP_ALU, DATA_W'(32'h104 + 4 * i), 1'b0);
    do_cdb(0, 0, 32'h0, 32'h200, 1'b1);
    do_cdb(1, 1, 32'h11, '0, 1'b0);
    n_checks++; if (commit_valid !== 1'b1 || commit_op !== OP_BRANCH || commit_addr !== 32'h200)
      $display("FAIL mp_head got cv=%b op=%0d addr=%h exp 1 3 200", commit_valid, commit_op, commit_addr);
    else n_pass++;
    commit_ready = 1; alloc_valid = 1; alloc_op = OP_ALU;
    next_cycle();
    commit_ready = 0; alloc_valid = 0; rd_tag = 4'd1;
    #1;
    n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h200)
      $display("FAIL mp_flush got flush=%b pc=%h exp 1 200", flush, flush_pc);
    else n_pass++;
    n_checks++; if (count !== '0 || commit_valid !== 1'b0 || alloc_tag !== '0 || rd_ready !== 1'b0)
      $display("FAIL mp_clear got count=%0d cv=%b tag=%0d rdr=%b exp 0 0 0 0",
               count, commit_valid, alloc_tag, rd_ready);
    else n_pass++;
    next_cycle();
    n_checks++; if (flush !== 1'b0) $display("FAIL mp_pulse got=%b exp=0", flush); else n_pass++;
    // Predicted taken, resolved not taken: redirect to the fall-through pc.
    t = alloc_tag;
    do_alloc(OP_BRANCH, 32'h300, 1'b1);
    do_cdb(1, int'(t), '0, 32'h999, 1'b0);
    commit_ready = 1;
    next_cycle();
    commit_ready = 0;
    n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h304)
      $display("FAIL mp_nt got flush=%b pc=%h exp 1 304", flush, flush_pc);
    else n_pass++;
    // Correct prediction retires quietly.
    t = alloc_tag;
    do_alloc(OP_BRANCH, 32'h400, 1'b1);
    do_cdb(0, int'(t), '0, 32'h500, 1'b1);
    commit_ready = 1;
    next_cycle();
    commit_ready = 0;
    n_checks++; if (flush !== 1'b0 || count !== '0)
      $display("FAIL mp_correct got flush=%b count=%0d exp 0 0", flush, count);
    else n_pass++;
  endtask

  task automatic test_dual_cdb();
    apply_reset();
    for (int i = 0; i < 6; i++) do_alloc(OP_ALU, DATA_W'(32'h600 + 4 * i), 1'b0);
    cdb_valid = 2'b11;
    cdb_tag = {4'd5, 4'd5};
    cdb_data = {32'hB, 32'hA};
    rd_tag = 4'd5;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    n_checks++; if (rd_ready !== 1'b1 || rd_data !== 32'hB)
      $display("FAIL dual_bypass got rdy=%b data=%h exp 1 b", rd_ready, rd_data);
    else n_pass++;
`else
    n_checks++; if (rd_ready !== 1'b0)
      $display("FAIL dual_nobypass got rdy=%b exp 0", rd_ready);
    else n_pass++;
`endif
    next_cycle();
    cdb_valid = '0;
    #1;
    n_checks++; if (rd_ready !== 1'b1 || rd_data !== 32'hB)
      $display("FAIL dual_stored got rdy=%b data=%h exp 1 b", rd_ready, rd_data);
    else n_pass++;
    do_cdb(0, 9, 32'h99, '0, 1'b0);
    rd_tag = 4'd9;
    #1;
    n_checks++; if (rd_ready !== 1'b0) $display("FAIL cdb_unoccupied got rdy=%b exp 0", rd_ready);
    else n_pass++;
  endtask

  task automatic test_halt();
    apply_reset();
    do_alloc(OP_HALT, 32'h700, 1'b0);
    do_alloc(OP_ALU, 32'h704, 1'b0);
    do_cdb(0, 1, 32'h77, '0, 1'b0);
    n_checks++; if (commit_valid !== 1'b1 || commit_op !== OP_HALT)
      $display("FAIL halt_head got cv=%b op=%0d exp 1 4", commit_valid, commit_op);
    else n_pass++;
    commit_ready = 1; alloc_valid = 1;
    for (int i = 0; i < 4; i++) next_cycle();
    n_checks++; if (halt !== 1'b1 || alloc_ready !== 1'b0 || commit_valid !== 1'b0 || count !== 5'd1)
      $display("FAIL halt_sticky got halt=%b rdy=%b cv=%b count=%0d exp 1 0 0 1",
               halt, alloc_ready, commit_valid, count);
    else n_pass++;
    #3;
    rst_n = 0;
    #1;
    n_checks++; if (halt !== 1'b0 || count !== '0 || commit_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL halt_reset got halt=%b count=%0d cv=%b flush=%b exp 0 0 0 0",
               halt, count, commit_valid, flush);
    else n_pass++;
    idle_inputs();
    #3;
    rst_n = 1;
    next_cycle();
    n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== '0)
      $display("FAIL halt_release got rdy=%b tag=%0d exp 1 0", alloc_ready, alloc_tag);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int flushes = 0;
    apply_reset();
    do_alloc(OP_BRANCH, 32'h800, 1'b0);
    do_cdb(0, 0, '0, 32'h900, 1'b1);
    commit_ready = 1;
    #2;
    rst_n = 0;
    #10;
    rst_n = 1;
    commit_ready = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (flush !== 1'b0) flushes++;
    end
    n_checks++; if (flushes != 0 || count !== '0)
      $display("FAIL reset_abort got flush_cycles=%0d count=%0d exp 0 0", flushes, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo();
    test_wrap();
    test_mispredict();
    test_dual_cdb();
    test_halt();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
